reorder_buffer: RTL and testbench

- Circular in-order reorder buffer: the responder side of the dispatch-to-ROB allocation interface.
- Accepts up to 3 ROB_ENTRY_PACKETs per cycle from dispatch and returns their ROB indices plus per-lane stall.
- Records out-of-order completions from the CDB.
- Retires up to 3 completed head entries per cycle to the free list and architectural map table; raises squash on a retiring precise-state entry and halt on a retiring halt entry.

---
 rtl/reorder_buffer_pkg.sv | 30 +++
 rtl/reorder_buffer_if.sv | 34 +++
 rtl/reorder_buffer_retire_sel.sv | 46 ++++
 rtl/reorder_buffer.sv | 137 +++++++++++++
 tb/tb_reorder_buffer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer slice.
//   ROB        : index width; ROB_DEPTH = 2**ROB entries so pointer math wraps for free
//   PR         : physical register tag width
//   XLEN       : PC width
//   rob_entry_packet_t : one ROB slot / one dispatch request
package reorder_buffer_pkg;

  localparam int ROB       = 5;
  localparam int ROB_DEPTH = 2 ** ROB;
  localparam int PR        = 6;
  localparam int XLEN      = 32;
  localparam int LANES     = 3;

  typedef struct packed {
    logic            valid;
    logic            halt;
    logic            completed;
    logic            precise_state_need;
    logic [4:0]      arch_reg;
    logic [PR-1:0]   Tnew;
    logic [PR-1:0]   Told;
    logic [XLEN-1:0] target_pc;
  } rob_entry_packet_t;

  // Number of set bits in a 3-lane strobe, sized for count arithmetic.
  function automatic logic [ROB:0] count_ones(input logic [LANES-1:0] v);
    return (ROB+1)'(v[0]) + (ROB+1)'(v[1]) + (ROB+1)'(v[2]);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / retire bundle between the pipeline and the reorder buffer.
//   master : pipeline side (drives dispatch requests and completions)
//   slave  : reorder buffer side (returns indices, stalls, retire and redirect info)
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  rob_entry_packet_t [2:0]           rob_in;
  logic [2:0]                        rob_stall;
  logic [2:0][ROB-1:0]               rob_index;
  logic [2:0]                        complete_valid;
  logic [2:0][ROB-1:0]               complete_entry;
  logic [2:0]                        complete_precise;
  logic [2:0][XLEN-1:0]              complete_target_pc;
  logic [2:0]                        retire_valid;
  logic [2:0][PR-1:0]                retire_Tnew;
  logic [2:0][PR-1:0]                retire_Told;
  logic [2:0][4:0]                   retire_arch_reg;
  logic                              squash;
  logic [XLEN-1:0]                   squash_pc;
  logic                              halt_out;

  modport master (
    output rob_in, complete_valid, complete_entry, complete_precise, complete_target_pc,
    input  rob_stall, rob_index, retire_valid, retire_Tnew, retire_Told, retire_arch_reg,
           squash, squash_pc, halt_out
  );

  modport slave (
    input  rob_in, complete_valid, complete_entry, complete_precise, complete_target_pc,
    output rob_stall, rob_index, retire_valid, retire_Tnew, retire_Told, retire_arch_reg,
           squash, squash_pc, halt_out
  );

endinterface

// File: rtl/reorder_buffer_retire_sel.sv
// Combinational 3-lane retire selector over the entries at head, head+1, head+2.
//   head_entries_i : the three oldest slots (lane 0 = head)
//   halted_i       : buffer is halted, nothing may retire
//   retire_valid_o : retiring lanes, always a prefix
//   squash_o / squash_lane_o : a retiring lane needs precise state, and which one
//   halt_o         : a retiring lane is a halt instruction
module rob_retire_sel
  import reorder_buffer_pkg::*;
(
  input  rob_entry_packet_t [2:0] head_entries_i,
  input  logic                    halted_i,
  output logic [2:0]              retire_valid_o,
  output logic                    squash_o,
  output logic [1:0]              squash_lane_o,
  output logic                    halt_o
);

  logic blocked;

  // NOTE: every variable driven here gets a default before any branch so no latch is inferred.
  always_comb begin
    retire_valid_o = '0;
    squash_o       = 1'b0;
    squash_lane_o  = '0;
    halt_o         = 1'b0;
    blocked        = halted_i;
    for (int k = 0; k < LANES; k++) begin
      if (!blocked && head_entries_i[k].valid && head_entries_i[k].completed) begin
        retire_valid_o[k] = 1'b1;
        // A precise or halt entry retires itself but ends the group.
        if (head_entries_i[k].precise_state_need) begin
          squash_o      = 1'b1;
          squash_lane_o = 2'(k);
          blocked       = 1'b1;
        end
        if (head_entries_i[k].halt) begin
          halt_o  = 1'b1;
          blocked = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer.
//   clock, reset : system clock, synchronous active-high reset
//   rob_if       : dispatch allocation (rob_in -> rob_index / rob_stall),
//                  CDB completions, retire to map table / free list, squash and halt
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  reorder_buffer_if.slave  rob_if
);

  logic [ROB-1:0]    head_q, head_d, tail_q, tail_d;
  logic [ROB:0]      count_q, count_d;
  logic              halted_q, halted_d;
  rob_entry_packet_t entries_q [ROB_DEPTH];
  rob_entry_packet_t entries_d [ROB_DEPTH];

  rob_entry_packet_t [2:0] head_entries;
  logic [2:0]        retire_valid, req_valid, alloc_v, stall;
  logic              squash, halt;
  logic [1:0]        squash_lane;
  logic [ROB:0]      free_slots, n_alloc, n_ret;
  logic [2:0][ROB-1:0] alloc_idx;
  logic [ROB-1:0]    offset;
  rob_entry_packet_t new_entry;

  always_comb begin
    for (int k = 0; k < LANES; k++) head_entries[k] = entries_q[head_q + ROB'(k)];
  end

  rob_retire_sel u_retire_sel (
    .head_entries_i (head_entries),
    .halted_i       (halted_q),
    .retire_valid_o (retire_valid),
    .squash_o       (squash),
    .squash_lane_o  (squash_lane),
    .halt_o         (halt)
  );

  // Stall depends only on registered count, never on this cycle's retires.
  assign free_slots = (ROB+1)'(ROB_DEPTH) - count_q;
  always_comb begin
    for (int i = 0; i < LANES; i++) stall[i] = (free_slots <= (ROB+1)'(i));
    if (squash || halt || halted_q) stall = '1;
  end

  // Compacting allocation: each valid lane takes the next free slot after tail.
  always_comb begin
    offset = tail_q;
    for (int i = 0; i < LANES; i++) begin
      req_valid[i] = rob_if.rob_in[i].valid;
      alloc_idx[i] = offset;
      if (req_valid[i]) offset = offset + 1'b1;
    end
  end

  assign alloc_v = req_valid & ~stall;
  assign n_alloc = count_ones(alloc_v);
  assign n_ret   = count_ones(retire_valid);

  always_comb begin
    entries_d = entries_q;
    new_entry = '0;
    // Later lanes overwrite earlier ones, so the highest duplicate strobe wins.
    for (int i = 0; i < LANES; i++) begin
      if (rob_if.complete_valid[i] && entries_q[rob_if.complete_entry[i]].valid) begin
        entries_d[rob_if.complete_entry[i]].completed          = 1'b1;
        entries_d[rob_if.complete_entry[i]].precise_state_need = rob_if.complete_precise[i];
        entries_d[rob_if.complete_entry[i]].target_pc          = rob_if.complete_target_pc[i];
      end
    end
    for (int k = 0; k < LANES; k++) begin
      if (retire_valid[k]) entries_d[head_q + ROB'(k)] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      if (alloc_v[i]) begin
        new_entry                    = rob_if.rob_in[i];
        new_entry.valid              = 1'b1;
        new_entry.completed          = 1'b0;
        new_entry.precise_state_need = 1'b0;
        new_entry.target_pc          = '0;
        entries_d[alloc_idx[i]]      = new_entry;
      end
    end
    head_d   = head_q + ROB'(n_ret);
    tail_d   = tail_q + ROB'(n_alloc);
    count_d  = count_q + n_alloc - n_ret;
    halted_d = halted_q | halt;
    // The precise entry retires; everything younger, plus this cycle's
    // completions, is discarded and the buffer restarts just past it.
    if (squash) begin
      for (int e = 0; e < ROB_DEPTH; e++) entries_d[e] = '0;
      tail_d  = head_d;
      count_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
      // NOTE: the entry array is cleared on reset because its valid bits define occupancy;
      // clearing whole entries also keeps the retire outputs at zero afterwards.
      for (int e = 0; e < ROB_DEPTH; e++) entries_q[e] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      halted_q  <= halted_d;
      entries_q <= entries_d;
    end
  end

  // Dispatch must never present a valid lane that is stalled.
  always_ff @(posedge clock) begin
    if (!reset) assert ((req_valid & stall) == 3'b000);
  end

  always_comb begin
    rob_if.rob_stall    = stall;
    rob_if.rob_index    = alloc_idx;
    rob_if.retire_valid = retire_valid;
    rob_if.squash       = squash;
    rob_if.squash_pc    = squash ? head_entries[squash_lane].target_pc : '0;
    rob_if.halt_out     = halt;
    for (int k = 0; k < LANES; k++) begin
      rob_if.retire_Tnew[k]     = retire_valid[k] ? head_entries[k].Tnew     : '0;
      rob_if.retire_Told[k]     = retire_valid[k] ? head_entries[k].Told     : '0;
      rob_if.retire_arch_reg[k] = retire_valid[k] ? head_entries[k].arch_reg : '0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  reorder_buffer_if bus ();
  reorder_buffer dut (.clock(clock), .reset(reset), .rob_if(bus));

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_in;
    bus.rob_in             = '0;
    bus.complete_valid     = '0;
    bus.complete_entry     = '0;
    bus.complete_precise   = '0;
    bus.complete_target_pc = '0;
  endtask

  function automatic rob_entry_packet_t mk(input int tnew, input logic h);
    rob_entry_packet_t e;
    e          = '0;
    e.valid    = 1'b1;
    e.halt     = h;
    e.Tnew     = PR'(tnew);
    e.Told     = PR'(tnew + 20);
    e.arch_reg = 5'(tnew);
    return e;
  endfunction

  task automatic set_cmp(input int lane, input int idx, input logic prec, input logic [XLEN-1:0] pc);
    bus.complete_valid[lane]     = 1'b1;
    bus.complete_entry[lane]     = ROB'(idx);
    bus.complete_precise[lane]   = prec;
    bus.complete_target_pc[lane] = pc;
  endtask

  task automatic do_reset;
    clear_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    total_cnt++; if (bus.rob_stall !== 3'b000) $display("FAIL reset_stall got %b want 000", bus.rob_stall); else pass_cnt++;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL reset_retire got %b want 000", bus.retire_valid); else pass_cnt++;
    total_cnt++; if ({bus.squash, bus.halt_out} !== 2'b00) $display("FAIL reset_squash_halt got %b want 00", {bus.squash, bus.halt_out}); else pass_cnt++;
    total_cnt++; if (bus.rob_index !== '0) $display("FAIL reset_index got %h want 0", bus.rob_index); else pass_cnt++;
    total_cnt++; if (bus.squash_pc !== '0) $display("FAIL reset_squash_pc got %h want 0", bus.squash_pc); else pass_cnt++;
  endtask

  // 11 cycles of dispatch: 3 lanes x 10, then 2 lanes once count hits 30.
  task automatic test_fill;
    logic [2:0] vmask;
    logic [2:0] exp_stall;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      clear_in();
      vmask     = (c == 10) ? 3'b011 : 3'b111;
      exp_stall = (c == 10) ? 3'b100 : 3'b000;
      for (int i = 0; i < LANES; i++) if (vmask[i]) bus.rob_in[i] = mk(c*3 + i, 1'b0);
      #1;
      total_cnt++; if (bus.rob_stall !== exp_stall) $display("FAIL fill_stall c=%0d got %b want %b", c, bus.rob_stall, exp_stall); else pass_cnt++;
      for (int i = 0; i < LANES; i++) begin
        if (vmask[i]) begin
          total_cnt++;
          if (bus.rob_index[i] !== ROB'(c*3 + i)) $display("FAIL fill_index c=%0d lane=%0d got %0d want %0d", c, i, bus.rob_index[i], c*3 + i);
          else pass_cnt++;
        end
      end
      tick();
    end
    clear_in();
    #1;
    total_cnt++; if (bus.rob_stall !== 3'b111) $display("FAIL full_stall got %b want 111", bus.rob_stall); else pass_cnt++;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL full_no_retire got %b want 000", bus.retire_valid); else pass_cnt++;
  endtask

  task automatic test_compact;
    do_reset();
    for (int i = 0; i < LANES; i++) bus.rob_in[i] = mk(i, 1'b0);
    tick();
    clear_in();
    bus.rob_in[0] = mk(3, 1'b0);
    bus.rob_in[1] = mk(4, 1'b0);
    tick();
    clear_in();
    bus.rob_in[0] = mk(5, 1'b0);
    bus.rob_in[2] = mk(6, 1'b0);
    #1;
    total_cnt++; if (bus.rob_index[0] !== 5'd5) $display("FAIL compact_lane0 got %0d want 5", bus.rob_index[0]); else pass_cnt++;
    total_cnt++; if (bus.rob_index[2] !== 5'd6) $display("FAIL compact_lane2 got %0d want 6", bus.rob_index[2]); else pass_cnt++;
    tick();
    clear_in();
    bus.rob_in[0] = mk(7, 1'b0);
    #1;
    total_cnt++; if (bus.rob_index[0] !== 5'd7) $display("FAIL compact_tail got %0d want 7", bus.rob_index[0]); else pass_cnt++;
    tick();
    clear_in();
  endtask

  task automatic test_inorder_retire;
    do_reset();
    for (int i = 0; i < LANES; i++) bus.rob_in[i] = mk(10 + i, 1'b0);
    tick();
    clear_in();
    set_cmp(0, 1, 1'b0, 32'h0);
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL inorder_none0 got %b want 000", bus.retire_valid); else pass_cnt++;
    tick();
    clear_in();
    set_cmp(0, 2, 1'b0, 32'h0);
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL inorder_none1 got %b want 000", bus.retire_valid); else pass_cnt++;
    tick();
    clear_in();
    set_cmp(0, 0, 1'b0, 32'h0);
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL inorder_same_cycle got %b want 000", bus.retire_valid); else pass_cnt++;
    tick();
    clear_in();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b111) $display("FAIL inorder_all got %b want 111", bus.retire_valid); else pass_cnt++;
    total_cnt++; if (bus.retire_Tnew !== {6'd12, 6'd11, 6'd10}) $display("FAIL inorder_tnew got %h want %h", bus.retire_Tnew, {6'd12, 6'd11, 6'd10}); else pass_cnt++;
    total_cnt++; if (bus.retire_Told !== {6'd32, 6'd31, 6'd30}) $display("FAIL inorder_told got %h want %h", bus.retire_Told, {6'd32, 6'd31, 6'd30}); else pass_cnt++;
    total_cnt++; if (bus.retire_arch_reg !== {5'd12, 5'd11, 5'd10}) $display("FAIL inorder_arch got %h want %h", bus.retire_arch_reg, {5'd12, 5'd11, 5'd10}); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL inorder_drained got %b want 000", bus.retire_valid); else pass_cnt++;
  endtask

  task automatic test_squash;
    do_reset();
    for (int i = 0; i < LANES; i++) bus.rob_in[i] = mk(i + 1, 1'b0);
    tick();
    clear_in();
    set_cmp(0, 0, 1'b0, 32'h0);
    set_cmp(1, 1, 1'b1, 32'h100);
    set_cmp(2, 2, 1'b0, 32'h0);
    tick();
    clear_in();
    set_cmp(0, 2, 1'b0, 32'h0);
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b011) $display("FAIL squash_retire got %b want 011", bus.retire_valid); else pass_cnt++;
    total_cnt++; if (bus.squash !== 1'b1) $display("FAIL squash_flag got %b want 1", bus.squash); else pass_cnt++;
    total_cnt++; if (bus.squash_pc !== 32'h100) $display("FAIL squash_pc got %h want 00000100", bus.squash_pc); else pass_cnt++;
    total_cnt++; if (bus.rob_stall !== 3'b111) $display("FAIL squash_stall got %b want 111", bus.rob_stall); else pass_cnt++;
    tick();
    clear_in();
    bus.rob_in[0] = mk(9, 1'b0);
    #1;
    total_cnt++; if (bus.rob_stall !== 3'b000) $display("FAIL post_squash_stall got %b want 000", bus.rob_stall); else pass_cnt++;
    total_cnt++; if (bus.squash !== 1'b0) $display("FAIL post_squash_flag got %b want 0", bus.squash); else pass_cnt++;
    total_cnt++; if (bus.rob_index[0] !== 5'd2) $display("FAIL post_squash_tail got %0d want 2", bus.rob_index[0]); else pass_cnt++;
    tick();
    clear_in();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL post_squash_retire got %b want 000", bus.retire_valid); else pass_cnt++;
  endtask

  task automatic test_halt;
    do_reset();
    bus.rob_in[0] = mk(5, 1'b1);
    bus.rob_in[1] = mk(6, 1'b0);
    tick();
    clear_in();
    set_cmp(0, 0, 1'b0, 32'h0);
    set_cmp(1, 1, 1'b0, 32'h0);
    #1;
    total_cnt++; if (bus.halt_out !== 1'b0) $display("FAIL halt_early got %b want 0", bus.halt_out); else pass_cnt++;
    tick();
    clear_in();
    #1;
    total_cnt++; if (bus.halt_out !== 1'b1) $display("FAIL halt_pulse got %b want 1", bus.halt_out); else pass_cnt++;
    total_cnt++; if (bus.retire_valid !== 3'b001) $display("FAIL halt_retire got %b want 001", bus.retire_valid); else pass_cnt++;
    total_cnt++; if (bus.retire_Tnew[0] !== 6'd5) $display("FAIL halt_tnew got %0d want 5", bus.retire_Tnew[0]); else pass_cnt++;
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      total_cnt++; if (bus.halt_out !== 1'b0) $display("FAIL halted_pulse c=%0d got %b want 0", c, bus.halt_out); else pass_cnt++;
      total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL halted_retire c=%0d got %b want 000", c, bus.retire_valid); else pass_cnt++;
      total_cnt++; if (bus.rob_stall !== 3'b111) $display("FAIL halted_stall c=%0d got %b want 111", c, bus.rob_stall); else pass_cnt++;
      tick();
    end
    do_reset();
    #1;
    total_cnt++; if (bus.rob_stall !== 3'b000) $display("FAIL halt_cleared got %b want 000", bus.rob_stall); else pass_cnt++;
  endtask

  task automatic test_wrap;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      clear_in();
      for (int i = 0; i < LANES; i++) bus.rob_in[i] = mk(c*3 + i, 1'b0);
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      clear_in();
      for (int i = 0; i < LANES; i++) set_cmp(i, c*3 + i, 1'b0, 32'h0);
      tick();
    end
    clear_in();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b111) $display("FAIL wrap_last_batch got %b want 111", bus.retire_valid); else pass_cnt++;
    total_cnt++; if (bus.retire_Tnew[0] !== 6'd27) $display("FAIL wrap_last_tnew got %0d want 27", bus.retire_Tnew[0]); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL wrap_empty_retire got %b want 000", bus.retire_valid); else pass_cnt++;
    for (int i = 0; i < LANES; i++) bus.rob_in[i] = mk(40 + i, 1'b0);
    #1;
    total_cnt++; if (bus.rob_index !== {5'd0, 5'd31, 5'd30}) $display("FAIL wrap_index got %h want %h", bus.rob_index, {5'd0, 5'd31, 5'd30}); else pass_cnt++;
    tick();
    clear_in();
    set_cmp(0, 10, 1'b1, 32'hdead);
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL wrap_stray_same got %b want 000", bus.retire_valid); else pass_cnt++;
    tick();
    clear_in();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL wrap_stray_retire got %b want 000", bus.retire_valid); else pass_cnt++;
    total_cnt++; if ({bus.rob_stall, bus.squash} !== 4'b0000) $display("FAIL wrap_stray_state got %b want 0000", {bus.rob_stall, bus.squash}); else pass_cnt++;
    set_cmp(0, 30, 1'b0, 32'h0);
    set_cmp(1, 31, 1'b0, 32'h0);
    set_cmp(2, 0, 1'b0, 32'h0);
    tick();
    clear_in();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b111) $display("FAIL wrap_retire got %b want 111", bus.retire_valid); else pass_cnt++;
    total_cnt++; if (bus.retire_Tnew !== {6'd42, 6'd41, 6'd40}) $display("FAIL wrap_tnew got %h want %h", bus.retire_Tnew, {6'd42, 6'd41, 6'd40}); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.retire_valid !== 3'b000) $display("FAIL wrap_drained got %b want 000", bus.retire_valid); else pass_cnt++;
  endtask

  initial begin
    clear_in();
    test_reset();
    test_fill();
    test_compact();
    test_inorder_retire();
    test_squash();
    test_halt();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
